mux_pipeline_stream: RTL
========================

MUX_PIPELINE_STREAM -- requirements
Module: mux_pipeline_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per input channel (>=1).
REQ-002 SHALL have parameter INPUT_COUNT, default 8: number of input channels (>=2).
REQ-003 SHALL have parameter RADIX, default 2: inputs per mux unit per level; power of two, >=2.
REQ-004 SHALL have parameter TAG_WIDTH, default 4: sideband tag bits carried with each beat (>=1).
REQ-005 SHALL derive localparams SEL_W = clog2(INPUT_COUNT) and LATENCY = ceil(log_RADIX(INPUT_COUNT)), with LATENCY >= 1.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1: beat offered.
REQ-009 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-010 SHALL have port sel, input, SEL_W+1: channel index; the extra MSB allows out-of-range detection.
REQ-011 SHALL have port in, input, WIDTH*INPUT_COUNT: channel k at in[k*WIDTH+:WIDTH].
REQ-012 SHALL have port in_tag, input, TAG_WIDTH: sideband tag travelling with the beat.
REQ-013 SHALL have port out_valid, output, 1: result present.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port out, output, WIDTH: selected channel data.
REQ-016 SHALL have port out_tag, output, TAG_WIDTH: tag of the same beat as out.
REQ-017 SHALL have port out_err, output, 1: beat had sel >= INPUT_COUNT.
REQ-018 SHALL have port inflight, output, clog2(LATENCY+1): count of valid beats currently held in pipeline registers.

Function
REQ-019 SHALL implement an N:1 mux as LATENCY levels of RADIX:1 units, each level followed by registers for data, remaining sel bits, tag, err and valid.
REQ-020 SHALL zero-fill unused unit inputs when INPUT_COUNT is not a power of RADIX.
REQ-021 SHALL consume sel LSB-first; each level uses clog2(RADIX) sel bits.
REQ-022 SHALL compute advance = !out_valid || out_ready and drive in_ready = advance.
REQ-023 SHALL shift all stages by one when advance = 1 and hold every stage unchanged when advance = 0 (global stall).
REQ-024 SHALL present an accepted beat on out/out_tag/out_err with out_valid = 1 exactly LATENCY cycles after acceptance when out_ready stays high.
REQ-025 SHALL sustain one beat per cycle, back-to-back, with no bubbles while out_ready = 1.
REQ-026 SHALL keep out, out_tag and out_err stable while out_valid && !out_ready.
REQ-027 SHALL, when sel >= INPUT_COUNT, deliver out = 0 and out_err = 1 for that beat, with the tag still carried.
REQ-028 SHALL set inflight = number of set stage-valid bits, range 0..LATENCY.
REQ-029 SHALL, on simultaneous acceptance and output consumption, leave inflight unchanged.
REQ-030 SHALL neither drop nor duplicate any beat under any in_valid/out_ready pattern.

Reset
REQ-031 SHALL, while rst = 1 at a clock edge, clear all stage-valid bits, out_valid, out, out_tag, out_err and inflight to 0 on that edge.
REQ-032 SHALL discard in-flight beats when reset is asserted mid-operation.
REQ-033 SHALL hold in_ready = 1 during and after reset, because the pipeline is empty.

Structure
REQ-034 SHALL place the level-count function (ceil log_RADIX), the per-level unit-count function and SEL_W computation in the shared header mux_pkg.vh.
REQ-035 SHALL instantiate one sub-module, mux_stage: one registered RADIX:1 level with a stall enable, generated LATENCY times.

Verification
All scenarios use WIDTH=8, INPUT_COUNT=5, RADIX=2 (LATENCY=3) unless stated.
REQ-036 SHALL cover single beat: in={55,44,33,22,11}h, sel=3, tag=9, one valid cycle, out_ready=1 -> out=44h, out_tag=9, out_err=0, out_valid high exactly 3 cycles later for 1 cycle.
REQ-037 SHALL cover streaming: sel=0,1,2,3,4 on consecutive cycles -> out=11h,22h,33h,44h,55h on 5 consecutive cycles starting at cycle 3.
REQ-038 SHALL cover backpressure: 3 beats in flight, then out_ready=0 for 4 cycles -> in_ready=0, out held constant, inflight=3; release -> all beats delivered in order, none lost.
REQ-039 SHALL cover out-of-range: sel=6 -> out=00h, out_err=1, tag preserved; the next beat with sel=1 -> out=22h, out_err=0.
REQ-040 SHALL cover reset mid-flight: 2 beats accepted, rst=1 for 1 cycle -> next cycle out_valid=0, inflight=0, in_ready=1; neither beat is ever output.
REQ-041 SHALL cover a second configuration, RADIX=4, INPUT_COUNT=16 (LATENCY=2): sel=13 -> channel 13 delivered 2 cycles after acceptance.

Source files
------------

// File: rtl/mux_pipeline_stream_pkg.sv
// Shared elaboration helpers for the pipelined stream multiplexer.
// mux_levels : number of RADIX:1 levels needed for n inputs, ceil(log_radix(n)), minimum 1
// mux_units  : number of mux units produced by a given level (0-based)
// mux_sel_w  : width of a channel index for n inputs
package mux_pipeline_stream_pkg;

  function automatic int mux_levels(input int n, input int radix);
    int lv;
    int span;
    lv   = 0;
    span = 1;
    while (span < n) begin
      span = span * radix;
      lv   = lv + 1;
    end
    if (lv < 1) begin
      lv = 1;
    end
    return lv;
  endfunction

  // Units after level 'level' = ceil(n / radix^(level+1)).
  function automatic int mux_units(input int n, input int radix, input int level);
    int u;
    u = n;
    for (int i = 0; i <= level; i++) begin
      u = (u + radix - 1) / radix;
    end
    return u;
  endfunction

  function automatic int mux_sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipeline_stream_stage.sv
// mux_stage: one registered RADIX:1 level of the multiplexer tree.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   adv            - stall enable; the stage loads only when high
//   d_valid/d_data/d_sel/d_tag/d_err - beat from the previous level
//   q_valid/q_data/q_sel/q_tag/q_err - registered beat for the next level
// Data buses are INPUT_COUNT units wide at every level; units beyond the
// level's real unit count are held at zero, which also zero-fills the unused
// inputs of the next level's last unit.
module mux_stage
  import mux_pipeline_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INPUT_COUNT = 8,
  parameter int RADIX       = 2,
  parameter int TAG_WIDTH   = 4,
  parameter int SEL_PW      = 3,
  parameter int LEVEL       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  input  logic                         d_valid,
  input  logic [INPUT_COUNT*WIDTH-1:0] d_data,
  input  logic [SEL_PW-1:0]            d_sel,
  input  logic [TAG_WIDTH-1:0]         d_tag,
  input  logic                         d_err,
  output logic                         q_valid,
  output logic [INPUT_COUNT*WIDTH-1:0] q_data,
  output logic [SEL_PW-1:0]            q_sel,
  output logic [TAG_WIDTH-1:0]         q_tag,
  output logic                         q_err
);

  localparam int LOG_R = $clog2(RADIX);
  localparam int N_IN  = (LEVEL == 0) ? INPUT_COUNT : mux_units(INPUT_COUNT, RADIX, LEVEL - 1);
  localparam int N_OUT = mux_units(INPUT_COUNT, RADIX, LEVEL);

  logic [INPUT_COUNT*WIDTH-1:0] mux_s;
  logic                         hit_s;

  // RADIX:1 selection per unit using the low sel bits; missing inputs read as zero
  always_comb begin
    mux_s = '0;
    hit_s = 1'b0;
    for (int j = 0; j < INPUT_COUNT; j++) begin
      for (int s = 0; s < RADIX; s++) begin
        hit_s = (j < N_OUT) && ((j * RADIX + s) < N_IN) && (int'(d_sel[LOG_R-1:0]) == s);
        mux_s[j*WIDTH +: WIDTH] = mux_s[j*WIDTH +: WIDTH] |
          (hit_s ? d_data[((j * RADIX + s) % INPUT_COUNT)*WIDTH +: WIDTH] : {WIDTH{1'b0}});
      end
    end
  end

  // Stage register: cleared on reset, loaded on advance, otherwise held
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_sel   <= '0;
      q_tag   <= '0;
      q_err   <= 1'b0;
    end else if (adv) begin
      q_valid <= d_valid;
      q_data  <= mux_s;
      q_sel   <= d_sel >> LOG_R;
      q_tag   <= d_tag;
      q_err   <= d_err;
    end else begin
      q_valid <= q_valid;
      q_data  <= q_data;
      q_sel   <= q_sel;
      q_tag   <= q_tag;
      q_err   <= q_err;
    end
  end

endmodule

// File: rtl/mux_pipeline_stream.sv
// mux_pipeline_stream: N:1 multiplexer built as LATENCY registered levels of
// RADIX:1 units, with valid/ready flow control and a global stall.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - input handshake (in_ready = !out_valid || out_ready)
//   sel                    - channel index, one extra MSB for out-of-range detection
//   in                     - channel k at in[k*WIDTH +: WIDTH]
//   in_tag                 - sideband tag travelling with the beat
//   out_valid/out_ready    - output handshake
//   out, out_tag, out_err  - selected data, its tag, out-of-range flag
//   inflight               - number of valid beats held in the pipeline
module mux_pipeline_stream
  import mux_pipeline_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INPUT_COUNT = 8,
  parameter int RADIX       = 2,
  parameter int TAG_WIDTH   = 4,
  localparam int SEL_W      = mux_sel_w(INPUT_COUNT),
  localparam int LATENCY    = mux_levels(INPUT_COUNT, RADIX),
  localparam int INF_W      = $clog2(LATENCY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W:0]               sel,
  input  logic [WIDTH*INPUT_COUNT-1:0] in,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         out_err,
  output logic [INF_W-1:0]             inflight
);

  localparam int LOG_R  = $clog2(RADIX);
  // Sel bits consumed by the whole tree, LSB-first, LOG_R per level
  localparam int SEL_PW = LATENCY * LOG_R;

  logic                         v_s    [LATENCY:0];
  logic [INPUT_COUNT*WIDTH-1:0] data_s [LATENCY:0];
  logic [SEL_PW-1:0]            sel_s  [LATENCY:0];
  logic [TAG_WIDTH-1:0]         tag_s  [LATENCY:0];
  logic                         err_s  [LATENCY:0];
  logic                         advance_s;
  logic [INF_W-1:0]             inflight_r;

  assign advance_s = !out_valid || out_ready;
  // Reset empties the pipeline, so input is always acceptable while it is held
  assign in_ready  = rst || advance_s;

  // Out-of-range beats enter with all channels zeroed so the tree yields zero
  assign err_s[0]  = (sel >= (SEL_W + 1)'(INPUT_COUNT));
  assign data_s[0] = err_s[0] ? {(WIDTH*INPUT_COUNT){1'b0}} : in;
  assign v_s[0]    = in_valid;
  assign tag_s[0]  = in_tag;

  if (SEL_PW > SEL_W + 1) begin : g_sel_ext
    assign sel_s[0] = {{(SEL_PW - SEL_W - 1){1'b0}}, sel};
  end else begin : g_sel_trunc
    assign sel_s[0] = sel[SEL_PW-1:0];
  end

  for (genvar l = 0; l < LATENCY; l++) begin : g_lvl
    mux_stage #(
      .WIDTH       (WIDTH),
      .INPUT_COUNT (INPUT_COUNT),
      .RADIX       (RADIX),
      .TAG_WIDTH   (TAG_WIDTH),
      .SEL_PW      (SEL_PW),
      .LEVEL       (l)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (advance_s),
      .d_valid (v_s[l]),
      .d_data  (data_s[l]),
      .d_sel   (sel_s[l]),
      .d_tag   (tag_s[l]),
      .d_err   (err_s[l]),
      .q_valid (v_s[l+1]),
      .q_data  (data_s[l+1]),
      .q_sel   (sel_s[l+1]),
      .q_tag   (tag_s[l+1]),
      .q_err   (err_s[l+1])
    );
  end

  assign out_valid = v_s[LATENCY];
  assign out       = data_s[LATENCY][WIDTH-1:0];
  assign out_tag   = tag_s[LATENCY];
  assign out_err   = err_s[LATENCY];
  assign inflight  = inflight_r;

  // Occupancy: a shift adds the entering beat and removes the leaving one
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= '0;
    end else if (advance_s) begin
      inflight_r <= inflight_r + INF_W'(in_valid) - INF_W'(v_s[LATENCY]);
    end else begin
      inflight_r <= inflight_r;
    end
  end

endmodule
